// File: rtl/led_sequence_scheduler.sv
// led_sequence_scheduler
// Steps the board RGB LED through four colour/duration slots, with
// start/stop/restart control, a programmable pass count (0 = forever)
// and a one-cycle completion pulse. Durations are in millisecond ticks
// derived from a PRESCALE-cycle prescaler. All outputs are registered.
module led_sequence_scheduler #(
    parameter int PRESCALE = 12000,
    parameter int DUR_W    = 12
) (
    input  logic             WBs_CLK_i,
    input  logic             WBs_RST_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [7:0]       loop_cnt_i,
    input  logic [DUR_W-1:0] duration0_i,
    input  logic [DUR_W-1:0] duration1_i,
    input  logic [DUR_W-1:0] duration2_i,
    input  logic [DUR_W-1:0] duration3_i,
    input  logic [2:0]       color0_i,
    input  logic [2:0]       color1_i,
    input  logic [2:0]       color2_i,
    input  logic [2:0]       color3_i,
    output logic             led_r_o,
    output logic             led_g_o,
    output logic             led_b_o,
    output logic             busy_o,
    output logic [1:0]       slot_o,
    output logic             done_o
);

    localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       slot_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [DUR_W-1:0] ms_reg;
    logic [7:0]       pass_reg;
    logic [7:0]       loop_reg;
    logic             zero_reg;   // current slot was entered with duration 0
    logic             busy_reg;
    logic             done_reg;
    logic [2:0]       led_reg;    // {r,g,b}

    // Slot inputs gathered into arrays so the entering slot can be muxed by index
    logic [DUR_W-1:0] dur_arr [4];
    logic [2:0]       col_arr [4];
    logic [3:0]       dur_nz;

    assign dur_arr[0] = duration0_i;
    assign dur_arr[1] = duration1_i;
    assign dur_arr[2] = duration2_i;
    assign dur_arr[3] = duration3_i;
    assign col_arr[0] = color0_i;
    assign col_arr[1] = color1_i;
    assign col_arr[2] = color2_i;
    assign col_arr[3] = color3_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dur_nz
            assign dur_nz[gi] = |dur_arr[gi];
        end
    endgenerate

    logic             tick;
    logic             slot_end;
    logic             last_pass;
    logic             all_zero;
    logic             stop_acc;
    logic             start_acc;
    logic [7:0]       pass_inc;
    logic [1:0]       ent_idx;
    logic [DUR_W-1:0] ent_dur;
    logic [2:0]       ent_led;

    // Decode control requests and the values a slot entry would latch
    always_comb begin
        tick      = (pre_reg == PRE_MAX);
        // A zero slot ends after its single cycle; otherwise on the wrap taking ms 1 -> 0
        slot_end  = zero_reg | (tick & (ms_reg == DUR_W'(1)));
        pass_inc  = pass_reg + 8'd1;
        last_pass = (loop_reg != 8'd0) && (pass_inc == loop_reg);
        all_zero  = ~|dur_nz;
        // Stop only matters in RUN, and there it overrides a coincident start
        stop_acc  = (state_reg == ST_RUN) & stop_i;
        start_acc = start_i & ~stop_acc;
        ent_idx   = start_acc ? 2'd0 : slot_reg + 2'd1;
        ent_dur   = dur_arr[ent_idx];
        // Zero slot keeps the previous colour, except right after a start (LEDs off)
        ent_led   = dur_nz[ent_idx] ? col_arr[ent_idx]
                                    : (start_acc ? 3'b000 : led_reg);
    end

    // Scheduler FSM with prescaler, ms counter, pass counter and registered outputs
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_reg <= ST_IDLE;
            slot_reg  <= 2'd0;
            pre_reg   <= '0;
            ms_reg    <= '0;
            pass_reg  <= 8'd0;
            loop_reg  <= 8'd0;
            zero_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            led_reg   <= 3'b000;
        end else begin
            done_reg <= 1'b0;
            if (stop_acc) begin
                state_reg <= ST_IDLE;
                slot_reg  <= 2'd0;
                busy_reg  <= 1'b0;
                led_reg   <= 3'b000;
            end else if (start_acc) begin
                loop_reg <= loop_cnt_i;
                pass_reg <= 8'd0;
                if (all_zero) begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                    slot_reg  <= 2'd0;
                    busy_reg  <= 1'b0;
                    led_reg   <= 3'b000;
                end else begin
                    state_reg <= ST_RUN;
                    slot_reg  <= ent_idx;
                    pre_reg   <= '0;
                    ms_reg    <= ent_dur;
                    zero_reg  <= ~dur_nz[ent_idx];
                    busy_reg  <= 1'b1;
                    led_reg   <= ent_led;
                end
            end else begin
                case (state_reg)
                    ST_RUN: begin
                        if (slot_end) begin
                            if (slot_reg == 2'd3) begin
                                pass_reg <= pass_inc;
                            end
                            if ((slot_reg == 2'd3) && last_pass) begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                                slot_reg  <= 2'd0;
                                busy_reg  <= 1'b0;
                                led_reg   <= 3'b000;
                            end else begin
                                slot_reg <= ent_idx;
                                pre_reg  <= '0;
                                ms_reg   <= ent_dur;
                                zero_reg <= ~dur_nz[ent_idx];
                                led_reg  <= ent_led;
                            end
                        end else if (tick) begin
                            pre_reg <= '0;
                            ms_reg  <= ms_reg - DUR_W'(1);
                        end else begin
                            pre_reg <= pre_reg + PRE_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign led_r_o = led_reg[2];
    assign led_g_o = led_reg[1];
    assign led_b_o = led_reg[0];
    assign busy_o  = busy_reg;
    assign slot_o  = slot_reg;
    assign done_o  = done_reg;

endmodule
